// File: rtl/jtag_tap_sampled.sv
// jtag_tap_sampled: IEEE 1149.1 TAP controller with TCK oversampled by clk_i.
// Instructions: IDCODE (0001), BYPASS (1111, and every unknown code), and
// CONFREG (0111), which exists only when JTAG_TAP_CONFREG_EN is defined.
// TCK/TMS/TDI/TRST pass through two-flop synchronizers. A TCK edge acts
// 3 clk_i cycles after it reaches the pin.
module jtag_tap_sampled #(
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0DB3,
  parameter int          IR_WIDTH     = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       jtag_tck_i,
  input  logic       jtag_trst_ni,
  input  logic       jtag_tms_i,
  input  logic       jtag_tdi_i,
  output logic       jtag_tdo_o,
  output logic       jtag_tdo_en_o,
  input  logic [8:0] confreg_i,
  output logic [8:0] confreg_o,
  output logic       confreg_upd_o
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] INS_IDCODE  = 4'b0001;
  localparam logic [IR_WIDTH-1:0] INS_CONFREG = 4'b0111;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE  = 4'b0101;

  tap_state_e          state_q, state_d;
  logic [1:0]          tck_sync_q, tck_sync_d, tms_sync_q, tms_sync_d;
  logic [1:0]          tdi_sync_q, tdi_sync_d, trst_sync_q, trst_sync_d;
  logic                tck_dly_q, tck_dly_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d, ir_sh_q, ir_sh_d;
  logic [31:0]         dr_sh_q, dr_sh_d;
  logic                tdo_q, tdo_d, tdo_en_q, tdo_en_d;
  logic [8:0]          confreg_q, confreg_d;
  logic                upd_q, upd_d;

  logic tck_s, tms_s, tdi_s, tap_rst, tck_rise, tck_fall;
  logic sel_idcode, sel_confreg;

  // Synchronizer shift, edge detect from synced TCK and its delayed copy
  always_comb begin
    tck_sync_d  = {tck_sync_q[0], jtag_tck_i};
    tms_sync_d  = {tms_sync_q[0], jtag_tms_i};
    tdi_sync_d  = {tdi_sync_q[0], jtag_tdi_i};
    trst_sync_d = {trst_sync_q[0], jtag_trst_ni};
    tck_s       = tck_sync_q[1];
    tms_s       = tms_sync_q[1];
    tdi_s       = tdi_sync_q[1];
    tap_rst     = ~trst_sync_q[1];
    tck_dly_d   = tck_s;
    tck_rise    = tck_s & ~tck_dly_q;
    tck_fall    = ~tck_s & tck_dly_q;
  end

  // Instruction decode; unknown codes fall through to BYPASS
  always_comb begin
    sel_idcode = (ir_q == INS_IDCODE);
`ifdef JTAG_TAP_CONFREG_EN
    sel_confreg = (ir_q == INS_CONFREG);
`else
    sel_confreg = 1'b0;
`endif
  end

`ifndef JTAG_TAP_CONFREG_EN
  logic unused_confreg;
  assign unused_confreg = ^confreg_i;
`endif

  // TAP state transitions on TCK rise; TRST overrides a coincident edge
  always_comb begin
    state_d = state_q;
    if (tap_rst) begin
      state_d = TLR;
    end else if (tck_rise) begin
      case (state_q)
        TLR:     state_d = tms_s ? TLR    : RTI;
        RTI:     state_d = tms_s ? SEL_DR : RTI;
        SEL_DR:  state_d = tms_s ? SEL_IR : CAP_DR;
        CAP_DR:  state_d = tms_s ? EX1_DR : SH_DR;
        SH_DR:   state_d = tms_s ? EX1_DR : SH_DR;
        EX1_DR:  state_d = tms_s ? UPD_DR : PA_DR;
        PA_DR:   state_d = tms_s ? EX2_DR : PA_DR;
        EX2_DR:  state_d = tms_s ? UPD_DR : SH_DR;
        UPD_DR:  state_d = tms_s ? SEL_DR : RTI;
        SEL_IR:  state_d = tms_s ? TLR    : CAP_IR;
        CAP_IR:  state_d = tms_s ? EX1_IR : SH_IR;
        SH_IR:   state_d = tms_s ? EX1_IR : SH_IR;
        EX1_IR:  state_d = tms_s ? UPD_IR : PA_IR;
        PA_IR:   state_d = tms_s ? EX2_IR : PA_IR;
        EX2_IR:  state_d = tms_s ? UPD_IR : SH_IR;
        UPD_IR:  state_d = tms_s ? SEL_DR : RTI;
        default: state_d = TLR;
      endcase
    end
  end

  // Capture/shift on TCK rise, TDO/update on TCK fall
  always_comb begin
    ir_d      = ir_q;
    ir_sh_d   = ir_sh_q;
    dr_sh_d   = dr_sh_q;
    tdo_d     = tdo_q;
    tdo_en_d  = tdo_en_q;
    confreg_d = confreg_q;
    upd_d     = 1'b0;
    if (tap_rst) begin
      ir_d     = INS_IDCODE;
      tdo_d    = 1'b0;
      tdo_en_d = 1'b0;
    end else begin
      if (state_q == TLR) ir_d = INS_IDCODE;
      if (tck_rise) begin
        case (state_q)
          CAP_IR: ir_sh_d = IR_CAPTURE;
          SH_IR:  ir_sh_d = {tdi_s, ir_sh_q[IR_WIDTH-1:1]};
          CAP_DR: begin
            if (sel_idcode) dr_sh_d = IDCODE_VALUE;
`ifdef JTAG_TAP_CONFREG_EN
            else if (sel_confreg) dr_sh_d = {23'b0, confreg_i};
`endif
            else dr_sh_d = '0;
          end
          SH_DR: begin
            if (sel_idcode)       dr_sh_d = {tdi_s, dr_sh_q[31:1]};
            else if (sel_confreg) dr_sh_d = {23'b0, tdi_s, dr_sh_q[8:1]};
            else                  dr_sh_d = {31'b0, tdi_s};
          end
          default: ;
        endcase
        // Release TDO as soon as the FSM leaves a shift state
        if (state_d != SH_IR && state_d != SH_DR) begin
          tdo_d    = 1'b0;
          tdo_en_d = 1'b0;
        end
      end
      if (tck_fall) begin
        case (state_q)
          SH_IR: begin
            tdo_d    = ir_sh_q[0];
            tdo_en_d = 1'b1;
          end
          SH_DR: begin
            tdo_d    = dr_sh_q[0];
            tdo_en_d = 1'b1;
          end
          UPD_IR: ir_d = ir_sh_q;
          UPD_DR: begin
            if (sel_confreg) begin
              confreg_d = dr_sh_q[8:0];
              upd_d     = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // All state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= TLR;
      tck_sync_q  <= '0;
      tms_sync_q  <= '0;
      tdi_sync_q  <= '0;
      trst_sync_q <= '0;
      tck_dly_q   <= 1'b0;
      ir_q        <= INS_IDCODE;
      ir_sh_q     <= '0;
      dr_sh_q     <= '0;
      tdo_q       <= 1'b0;
      tdo_en_q    <= 1'b0;
      confreg_q   <= 9'h000;
      upd_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tck_sync_q  <= tck_sync_d;
      tms_sync_q  <= tms_sync_d;
      tdi_sync_q  <= tdi_sync_d;
      trst_sync_q <= trst_sync_d;
      tck_dly_q   <= tck_dly_d;
      ir_q        <= ir_d;
      ir_sh_q     <= ir_sh_d;
      dr_sh_q     <= dr_sh_d;
      tdo_q       <= tdo_d;
      tdo_en_q    <= tdo_en_d;
      confreg_q   <= confreg_d;
      upd_q       <= upd_d;
    end
  end

  assign jtag_tdo_o    = tdo_q;
  assign jtag_tdo_en_o = tdo_en_q;
  assign confreg_o     = confreg_q;
  assign confreg_upd_o = upd_q;

endmodule

// File: tb/tb_jtag_tap_sampled.sv
// Directed bench for jtag_tap_sampled. TCK is driven with 6 clk_i cycles per
// phase. Expectations follow the build: CONFREG behaviour when
// JTAG_TAP_CONFREG_EN is defined, BYPASS behaviour for 0111 otherwise.
module tb_jtag_tap_sampled;

`ifdef JTAG_TAP_CONFREG_EN
  localparam bit CONF_EN = 1'b1;
`else
  localparam bit CONF_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       jtag_tck_i, jtag_trst_ni, jtag_tms_i, jtag_tdi_i;
  logic       jtag_tdo_o, jtag_tdo_en_o;
  logic [8:0] confreg_i, confreg_o;
  logic       confreg_upd_o;

  int vecs = 0;
  int errs = 0;
  int upd_cnt = 0;
  int upd_base;
  logic [31:0] dout;

  jtag_tap_sampled dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .jtag_tck_i   (jtag_tck_i),
    .jtag_trst_ni (jtag_trst_ni),
    .jtag_tms_i   (jtag_tms_i),
    .jtag_tdi_i   (jtag_tdi_i),
    .jtag_tdo_o   (jtag_tdo_o),
    .jtag_tdo_en_o(jtag_tdo_en_o),
    .confreg_i    (confreg_i),
    .confreg_o    (confreg_o),
    .confreg_upd_o(confreg_upd_o)
  );

  always #5 clk = ~clk;

  // Count confreg update pulses, sampled away from the active edge
  always @(negedge clk) if (confreg_upd_o === 1'b1) upd_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full TCK period: rise, 6 clk high, fall, 6 clk low
  task automatic step(input logic t, input logic d);
    jtag_tms_i = t;
    jtag_tdi_i = d;
    jtag_tck_i = 1'b1;
    #60;
    jtag_tck_i = 1'b0;
    #60;
  endtask

  // From Run-Test/Idle: scan n bits LSB-first, update, back to Run-Test/Idle
  task automatic scan(input bit is_ir, input int n, input logic [31:0] din,
                      output logic [31:0] q);
    q = '0;
    step(1'b1, 1'b0);
    if (is_ir) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    q[0] = jtag_tdo_o;
    check(is_ir ? "tdo_en_ir" : "tdo_en_dr", {31'b0, jtag_tdo_en_o}, 32'd1);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i]);
      if (i < n - 1) q[i+1] = jtag_tdo_o;
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    jtag_tck_i = 1'b0; jtag_trst_ni = 1'b1; jtag_tms_i = 1'b1; jtag_tdi_i = 1'b0;
    confreg_i = 9'h000;
    #30;
    check("rst_tdo",     {31'b0, jtag_tdo_o},    32'd0);
    check("rst_tdo_en",  {31'b0, jtag_tdo_en_o}, 32'd0);
    check("rst_confreg", {23'b0, confreg_o},     32'd0);
    check("rst_upd",     {31'b0, confreg_upd_o}, 32'd0);
    rst = 1'b0;
    #40;

    // TRST pulse, then IDCODE read
    jtag_trst_ni = 1'b0;
    #100;
    jtag_trst_ni = 1'b1;
    #40;
    step(1'b0, 1'b0);
    scan(1'b0, 32, 32'h0, dout);
    check("idcode", dout, 32'h1000_0DB3);
    check("idle_tdo_en", {31'b0, jtag_tdo_en_o}, 32'd0);

    // BYPASS: TDO trails TDI by one TCK
    scan(1'b1, 4, 32'hF, dout);
    check("ir_cap_bypass", dout, 32'h5);
    scan(1'b0, 9, 32'h0A5, dout);
    check("bypass_a5", dout, 32'h14A);

    // CONFREG capture/update (BYPASS when the feature is absent)
    confreg_i = 9'h1C0;
    scan(1'b1, 4, 32'h7, dout);
    check("ir_cap_conf", dout, 32'h5);
    upd_base = upd_cnt;
    scan(1'b0, 9, 32'h002, dout);
    check("confreg_tdo", dout, CONF_EN ? 32'h1C0 : 32'h004);
    check("confreg_o",   {23'b0, confreg_o}, CONF_EN ? 32'h002 : 32'h000);
    check("confreg_upd_pulses", upd_cnt - upd_base, CONF_EN ? 32'd1 : 32'd0);

    // Unknown opcode behaves as BYPASS
    scan(1'b1, 4, 32'hA, dout);
    check("ir_cap_1010", dout, 32'h5);
    scan(1'b0, 2, 32'h3, dout);
    check("unk_bypass", dout, 32'h2);

    // Five TMS=1 rises from Shift-DR reach Test-Logic-Reset
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    check("shdr_tdo_en", {31'b0, jtag_tdo_en_o}, 32'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tlr_tdo_en",  {31'b0, jtag_tdo_en_o}, 32'd0);
    check("tlr_confreg", {23'b0, confreg_o}, CONF_EN ? 32'h002 : 32'h000);
    step(1'b0, 1'b0);
    scan(1'b0, 32, 32'h0, dout);
    check("tlr_idcode", dout, 32'h1000_0DB3);

    // TRST after 4 bits of a 9-bit CONFREG shift aborts the scan
    scan(1'b1, 4, 32'h7, dout);
    upd_base = upd_cnt;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    check("mid_tdo_en", {31'b0, jtag_tdo_en_o}, 32'd1);
    jtag_trst_ni = 1'b0;
    #30;
    check("trst_tdo_en", {31'b0, jtag_tdo_en_o}, 32'd0);
    check("trst_tdo",    {31'b0, jtag_tdo_o},    32'd0);
    #50;
    check("trst_no_upd", upd_cnt - upd_base, 32'd0);
    check("trst_confreg", {23'b0, confreg_o}, CONF_EN ? 32'h002 : 32'h000);
    jtag_trst_ni = 1'b1;
    #40;
    step(1'b0, 1'b0);
    scan(1'b0, 32, 32'h0, dout);
    check("trst_idcode", dout, 32'h1000_0DB3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/jtag_tap_sampled.md
JTAG_TAP_SAMPLED -- requirements
Module: jtag_tap_sampled

Interface
REQ-001 SHALL have parameter IDCODE_VALUE, default 32'h1000_0DB3, the 32-bit value captured by IDCODE; bit 0 is 1.
REQ-002 SHALL have parameter IR_WIDTH, default 4, the instruction register width; the only legal value is 4.
REQ-003 SHALL have port clk_i, input, 1 bit: the single system clock; all flops are clocked on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port jtag_tck_i, input, 1 bit: JTAG TCK, oversampled by clk_i.
REQ-006 SHALL have port jtag_trst_ni, input, 1 bit: JTAG TRST, active low, synchronized.
REQ-007 SHALL have port jtag_tms_i, input, 1 bit: JTAG TMS.
REQ-008 SHALL have port jtag_tdi_i, input, 1 bit: JTAG TDI.
REQ-009 SHALL have port jtag_tdo_o, output, 1 bit: JTAG TDO.
REQ-010 SHALL have port jtag_tdo_en_o, output, 1 bit: TDO drive enable, high only in Shift-IR or Shift-DR.
REQ-011 SHALL have port confreg_i, input, 9 bits: status value captured into the config register in Capture-DR.
REQ-012 SHALL have port confreg_o, output, 9 bits: the last updated config register value.
REQ-013 SHALL have port confreg_upd_o, output, 1 bit: one clk_i pulse when confreg_o is updated.

Function
REQ-014 SHALL synchronize jtag_tck_i, jtag_tms_i, jtag_tdi_i and jtag_trst_ni with two-flop synchronizers.
REQ-015 SHALL detect TCK rise and fall from the synchronized TCK and its one-cycle-delayed copy; edge-to-action latency SHALL be 3 clk_i cycles.
REQ-016 SHALL operate correctly only when TCK high and low phases each last at least 4 clk_i cycles; behaviour with shorter phases is undefined.
REQ-017 SHALL implement the 16-state IEEE 1149.1 TAP FSM, advancing on each TCK rise using the synchronized TMS.
REQ-018 SHALL enter Test-Logic-Reset after 5 consecutive TCK rises with TMS=1, from any state.
REQ-019 SHALL, in Test-Logic-Reset, load IR with IDCODE (4'b0001).
REQ-020 SHALL decode instructions IDCODE=4'b0001, CONFREG=4'b0111 and BYPASS=4'b1111; every other code SHALL select BYPASS.
REQ-021 SHALL load the IR shift register with 4'b0101 at Capture-IR.
REQ-022 SHALL, at Capture-DR, load the selected data register: IDCODE_VALUE, confreg_i, or 1'b0 for BYPASS.
REQ-023 SHALL, in Shift-IR/Shift-DR, shift TDI into the MSB and shift out LSB-first, on TCK rise.
REQ-024 SHALL update jtag_tdo_o from the shift-register LSB on TCK fall (negedge-TCK semantics).
REQ-025 SHALL hold jtag_tdo_o at 0 when jtag_tdo_en_o is 0.
REQ-026 SHALL, at Update-IR, copy the IR shift register to IR on TCK fall.
REQ-027 SHALL, at Update-DR with CONFREG selected, copy the 9-bit shift register to confreg_o on TCK fall.
REQ-028 SHALL pulse confreg_upd_o in the same clk_i cycle that confreg_o changes.
REQ-029 SHALL make BYPASS a 1-bit register, so TDO reproduces TDI delayed by one TCK.
REQ-030 SHALL, when a TCK edge and TRST assertion coincide, give TRST priority.

Reset
REQ-031 SHALL, on rst_i=1, asynchronously set: FSM=Test-Logic-Reset, IR=IDCODE, shift registers=0, confreg_o=9'h000, confreg_upd_o=0, jtag_tdo_o=0, jtag_tdo_en_o=0, synchronizers=0.
REQ-032 SHALL treat synchronized jtag_trst_ni=0 as a synchronous TAP reset: FSM=Test-Logic-Reset, IR=IDCODE, tdo_en=0; confreg_o SHALL be retained.
REQ-033 SHALL, on TRST mid-shift, abort the shift with no update to IR or confreg_o.

Configuration
REQ-034 SHALL, with JTAG_TAP_CONFREG_EN defined, implement the CONFREG instruction and register as above.
REQ-035 SHALL, without JTAG_TAP_CONFREG_EN, decode 4'b0111 as BYPASS, tie confreg_o to 9'h000 and confreg_upd_o to 0, and leave confreg_i unused.

Verification
REQ-036 SHALL cover: rst_i, TRST pulse, then 32-bit IDCODE DR scan -> TDO LSB-first = 32'h1000_0DB3.
REQ-037 SHALL cover: IR=4'b1111, DR scan of 8'hA5 followed by one 0 -> TDO = 0 followed by 8'hA5, i.e. 1-TCK delay.
REQ-038 SHALL cover: IR=4'b0111, confreg_i=9'h1C0, shift in 9'h002 -> TDO = 9'h1C0, confreg_o=9'h002, a single confreg_upd_o pulse.
REQ-039 SHALL cover: IR shift of 4'b1010 -> Capture-IR TDO = 4'b0101, then 2-bit DR scan behaves as BYPASS.
REQ-040 SHALL cover: TMS=1 for 5 TCK from Shift-DR -> Test-Logic-Reset, IR=IDCODE, confreg_o unchanged.
REQ-041 SHALL cover: TRST asserted after 4 bits of a 9-bit CONFREG shift -> no confreg_upd_o, tdo_en_o=0 within 3 clk_i cycles.
